// File: rtl/led_bar_sched.sv
// Shares one LED bar-graph datapath between CH_NR measurement channels.
// Latches per-channel values and sequences clear/update pulses on every channel switch.
module led_bar_sched #(
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned CH_NR       = 3,
   parameter int unsigned SEL_W       = 2,
   parameter int unsigned DWELL_TICKS = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CH_NR*DATA_W-1:0]   ch_data_i,
   input  logic [CH_NR-1:0]          ch_valid_i,
   input  logic                      auto_i,
   input  logic [SEL_W-1:0]          ch_sel_i,
   input  logic                      tick_i,
   input  logic                      hold_i,
   input  logic                      clr_i,
   output logic [DATA_W-1:0]         bar_din_o,
   output logic                      bar_update_o,
   output logic                      bar_clr_o,
   output logic [SEL_W-1:0]          active_ch_o
);

   localparam int unsigned DwellW = $clog2(DWELL_TICKS + 1);

   typedef enum logic [1:0] {StInit, StClr, StUpd, StShow} state_e;

   state_e                  state_q;
   logic [DATA_W-1:0]       latch_q [CH_NR];
   logic [DATA_W-1:0]       latch_d [CH_NR];
   logic [CH_NR-1:0]        has_data_q;
   logic [CH_NR-1:0]        has_data_d;
   logic [DwellW-1:0]       dwell_q;

   logic                    act_valid;
   logic                    act_has_d;
   logic [DATA_W-1:0]       act_data_d;
   logic [SEL_W-1:0]        sel_eff;
   logic                    rr_found;
   logic [SEL_W-1:0]        rr_ch;
   logic                    tick_cnt;
   logic                    reach;
   logic                    switch_req;
   logic [SEL_W-1:0]        target_ch;

   // Next latch contents: clr_i wins over a same-cycle valid.
   always_comb begin
      has_data_d = has_data_q;
      for (int unsigned k = 0; k < CH_NR; k++) begin
         latch_d[k] = latch_q[k];
         if (clr_i) begin
            latch_d[k]    = '0;
            has_data_d[k] = 1'b0;
         end else if (ch_valid_i[k]) begin
            latch_d[k]    = ch_data_i[k*DATA_W +: DATA_W];
            has_data_d[k] = 1'b1;
         end
      end
   end

   always_comb begin
      act_valid  = 1'b0;
      act_has_d  = 1'b0;
      act_data_d = '0;
      for (int unsigned k = 0; k < CH_NR; k++) begin
         if (active_ch_o == SEL_W'(k)) begin
            act_valid  = ch_valid_i[k];
            act_has_d  = has_data_d[k];
            act_data_d = latch_d[k];
         end
      end
   end

   // Round-robin search for the next channel after the active one that holds data.
   always_comb begin
      int unsigned cand;
      rr_found = 1'b0;
      rr_ch    = active_ch_o;
      for (int unsigned i = 1; i < CH_NR; i++) begin
         cand = 32'(active_ch_o) + i;
         if (cand >= CH_NR) cand = cand - CH_NR;
         for (int unsigned k = 0; k < CH_NR; k++) begin
            if (!rr_found && has_data_q[k] && (k == cand)) begin
               rr_found = 1'b1;
               rr_ch    = SEL_W'(k);
            end
         end
      end
   end

   always_comb begin
      sel_eff  = (32'(ch_sel_i) >= CH_NR) ? '0 : ch_sel_i;
      tick_cnt = (state_q == StShow) && auto_i && tick_i && !hold_i;
      reach    = tick_cnt && (dwell_q == DwellW'(DWELL_TICKS - 1));
      if (auto_i) begin
         target_ch  = rr_ch;
         switch_req = reach && rr_found;
      end else begin
         target_ch  = sel_eff;
         switch_req = (sel_eff != active_ch_o);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StInit;
         has_data_q   <= '0;
         dwell_q      <= '0;
         bar_din_o    <= '0;
         bar_update_o <= 1'b0;
         bar_clr_o    <= 1'b0;
         active_ch_o  <= '0;
         for (int unsigned k = 0; k < CH_NR; k++) latch_q[k] <= '0;
      end else begin
         latch_q      <= latch_d;
         has_data_q   <= has_data_d;
         bar_update_o <= 1'b0;
         bar_clr_o    <= 1'b0;
         if (clr_i) begin
            state_q   <= StClr;
            dwell_q   <= '0;
            bar_din_o <= '0;
            bar_clr_o <= 1'b1;
         end else begin
            unique case (state_q)
               StInit: begin
                  state_q   <= StClr;
                  bar_clr_o <= 1'b1;
               end
               StClr: begin
                  state_q <= StUpd;
                  if (act_has_d) begin
                     bar_update_o <= 1'b1;
                     bar_din_o    <= act_data_d;
                  end
               end
               StUpd: begin
                  state_q <= StShow;
                  if (act_valid) begin
                     bar_update_o <= 1'b1;
                     bar_din_o    <= act_data_d;
                  end
               end
               StShow: begin
                  if (!auto_i || reach) dwell_q <= '0;
                  else if (tick_cnt) dwell_q <= dwell_q + 1'b1;
                  // A switch suppresses the active-channel update; the value stays latched.
                  if (switch_req) begin
                     active_ch_o <= target_ch;
                     dwell_q     <= '0;
                     state_q     <= StClr;
                     bar_clr_o   <= 1'b1;
                  end else if (act_valid) begin
                     bar_update_o <= 1'b1;
                     bar_din_o    <= act_data_d;
                  end
               end
               default: state_q <= StInit;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_bar_sched.sv
// Self-checking bench for led_bar_sched: behavioural model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_led_bar_sched;

   localparam int unsigned DW    = 4;
   localparam int unsigned CHN   = 3;
   localparam int unsigned SW    = 2;
   localparam int unsigned DWELL = 2;

   logic              clk;
   logic              rst;
   logic [CHN*DW-1:0] ch_data;
   logic [CHN-1:0]    ch_valid;
   logic              auto_m;
   logic [SW-1:0]     ch_sel;
   logic              tick;
   logic              hold;
   logic              clr;
   logic [DW-1:0]     bar_din;
   logic              bar_update;
   logic              bar_clr;
   logic [SW-1:0]     active_ch;

   int checks = 0;
   int errors = 0;
   bit run    = 1'b0;

   // Model state: phase 0 = init, 1 = clear shown, 2 = update shown, 3 = showing.
   logic [DW-1:0] m_latch [CHN];
   bit            m_has   [CHN];
   int            m_act;
   int            m_dwell;
   int            m_phase;
   bit            e_clr;
   bit            e_upd;
   logic [DW-1:0] e_din;

   led_bar_sched #(
      .DATA_W      (DW),
      .CH_NR       (CHN),
      .SEL_W       (SW),
      .DWELL_TICKS (DWELL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_data_i    (ch_data),
      .ch_valid_i   (ch_valid),
      .auto_i       (auto_m),
      .ch_sel_i     (ch_sel),
      .tick_i       (tick),
      .hold_i       (hold),
      .clr_i        (clr),
      .bar_din_o    (bar_din),
      .bar_update_o (bar_update),
      .bar_clr_o    (bar_clr),
      .active_ch_o  (active_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < CHN; k++) begin
         m_latch[k] = '0;
         m_has[k]   = 1'b0;
      end
      m_act = 0; m_dwell = 0; m_phase = 0;
      e_clr = 1'b0; e_upd = 1'b0; e_din = '0;
   endtask

   task automatic model_step();
      bit prev_has [CHN];
      bit act_v;
      int target;
      int cand;
      bit found;
      e_clr = 1'b0;
      e_upd = 1'b0;
      if (clr) begin
         for (int k = 0; k < CHN; k++) begin
            m_latch[k] = '0;
            m_has[k]   = 1'b0;
         end
         m_dwell = 0; e_din = '0; e_clr = 1'b1; m_phase = 1;
      end else begin
         for (int k = 0; k < CHN; k++) prev_has[k] = m_has[k];
         act_v = ch_valid[m_act];
         for (int k = 0; k < CHN; k++) begin
            if (ch_valid[k]) begin
               m_latch[k] = ch_data[k*DW +: DW];
               m_has[k]   = 1'b1;
            end
         end
         if (m_phase == 0) begin
            m_phase = 1; e_clr = 1'b1;
         end else if (m_phase == 1) begin
            m_phase = 2;
            if (m_has[m_act]) begin e_upd = 1'b1; e_din = m_latch[m_act]; end
         end else if (m_phase == 2) begin
            m_phase = 3;
            if (act_v) begin e_upd = 1'b1; e_din = m_latch[m_act]; end
         end else begin
            target = m_act;
            if (!auto_m) begin
               m_dwell = 0;
               target  = (int'(ch_sel) >= CHN) ? 0 : int'(ch_sel);
            end else if (tick && !hold) begin
               m_dwell++;
               if (m_dwell == DWELL) begin
                  m_dwell = 0;
                  found   = 1'b0;
                  for (int off = 1; off < CHN; off++) begin
                     cand = (m_act + off) % CHN;
                     if (!found && prev_has[cand]) begin found = 1'b1; target = cand; end
                  end
               end
            end
            if (target != m_act) begin
               m_act = target; m_dwell = 0; m_phase = 1; e_clr = 1'b1;
            end else if (act_v) begin
               e_upd = 1'b1; e_din = m_latch[m_act];
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("model_clr", 32'(bar_clr), 32'(e_clr));
         chk("model_upd", 32'(bar_update), 32'(e_upd));
         chk("model_din", 32'(bar_din), 32'(e_din));
         chk("model_act", 32'(active_ch), 32'(m_act));
      end
   end

   task automatic cyc();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
   endtask

   task automatic valid_cyc(input int k, input logic [DW-1:0] v);
      ch_data[k*DW +: DW] = v;
      ch_valid = 3'(1 << k);
      cyc();
      ch_valid = '0;
   endtask

   initial begin
      rst = 1'b1; ch_data = '0; ch_valid = '0; auto_m = 1'b0; ch_sel = '0;
      tick = 1'b0; hold = 1'b0; clr = 1'b0;
      model_reset();
      run = 1'b1;
      cyc(); cyc();
      chk("rst_clr", 32'(bar_clr), 0);
      chk("rst_act", 32'(active_ch), 0);
      chk("rst_din", 32'(bar_din), 0);

      // 1: startup clear, then update on active channel 0
      rst = 1'b0;
      cyc();
      chk("init_clr", 32'(bar_clr), 1);
      cyc();
      chk("init_noupd", 32'(bar_update), 0);
      cyc();
      valid_cyc(0, 4'h5);
      chk("t1_upd", 32'(bar_update), 1);
      chk("t1_din", 32'(bar_din), 32'h5);

      // 2: manual switch to ch1, then out-of-range select maps to ch0
      valid_cyc(1, 4'hA);
      chk("t2_noupd", 32'(bar_update), 0);
      ch_sel = 2'd1;
      cyc();
      chk("t2_act1", 32'(active_ch), 1);
      chk("t2_clr", 32'(bar_clr), 1);
      cyc();
      chk("t2_din", 32'(bar_din), 32'hA);
      cyc();
      ch_sel = 2'd3;
      cyc();
      chk("t2_act0", 32'(active_ch), 0);
      cyc(); cyc();

      // 3: auto round-robin skipping empty ch1, hold freezes dwell
      clr = 1'b1; cyc(); clr = 1'b0;
      cyc(); cyc();
      valid_cyc(0, 4'h3);
      valid_cyc(2, 4'hC);
      auto_m = 1'b1;
      cyc();
      tick = 1'b1; cyc(); tick = 1'b0;
      hold = 1'b1; tick = 1'b1; cyc(); tick = 1'b0; hold = 1'b0;
      chk("t3_hold_act", 32'(active_ch), 0);
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("t3_act2", 32'(active_ch), 2);
      cyc();
      chk("t3_dinC", 32'(bar_din), 32'hC);
      cyc();
      tick = 1'b1; cyc(); cyc(); tick = 1'b0;
      chk("t3_back0", 32'(active_ch), 0);
      cyc();
      chk("t3_din3", 32'(bar_din), 32'h3);
      cyc();

      // 4: only ch0 has data -> expiry keeps channel, no clear
      clr = 1'b1; cyc(); clr = 1'b0;
      cyc(); cyc();
      valid_cyc(0, 4'h6);
      tick = 1'b1; cyc(); cyc(); tick = 1'b0;
      chk("t4_noclr", 32'(bar_clr), 0);
      chk("t4_act", 32'(active_ch), 0);
      cyc();

      // 5: valids during CLR and UPD of a switch to ch2
      auto_m = 1'b0; ch_sel = 2'd2;
      cyc();
      chk("t5_act2", 32'(active_ch), 2);
      valid_cyc(2, 4'h7);
      chk("t5_upd7", 32'(bar_update), 1);
      chk("t5_din7", 32'(bar_din), 32'h7);
      valid_cyc(2, 4'h9);
      chk("t5_din9", 32'(bar_din), 32'h9);
      cyc();

      // 6: clr_i beats active valid; async reset mid-UPD
      clr = 1'b1; ch_data[2*DW +: DW] = 4'h4; ch_valid = 3'b100;
      cyc();
      clr = 1'b0; ch_valid = '0;
      chk("t6_clr", 32'(bar_clr), 1);
      chk("t6_noupd", 32'(bar_update), 0);
      chk("t6_din0", 32'(bar_din), 0);
      cyc();
      chk("t6_upd_none", 32'(bar_update), 0);
      cyc();
      ch_sel = 2'd0;
      cyc();
      valid_cyc(0, 4'hB);
      chk("t6_updB", 32'(bar_din), 32'hB);
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("t6_rst_upd", 32'(bar_update), 0);
      chk("t6_rst_din", 32'(bar_din), 0);
      chk("t6_rst_act", 32'(active_ch), 0);
      chk("t6_rst_clr", 32'(bar_clr), 0);
      @(negedge clk);
      cyc();
      rst = 1'b0;
      cyc();
      chk("t6_reinit_clr", 32'(bar_clr), 1);
      cyc(); cyc(); cyc();

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
